// File: rtl/mmio_timer_if.sv
// CPU data-memory bus as seen by the timer: address, write strobe and data in;
// registered read data and window hit out.
interface mmio_timer_if;
  logic [31:0] mem_addr;
  logic        wr_en;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        rd_hit;

  modport master (output mem_addr, wr_en, w_data, input r_data, rd_hit);
  modport slave  (input mem_addr, wr_en, w_data, output r_data, rd_hit);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer: prescaler, 32-bit down-counter, sticky expiry and level irq.
// Optional CAPTURE register at offset 0x14 when MMIO_TIMER_CAPTURE_EN is defined.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        clk_en,
  mmio_timer_if.slave bus,
  output logic        irq
);

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_LOAD   = 3'd1,
    OFF_COUNT  = 3'd2,
    OFF_STATUS = 3'd3,
    OFF_PRESC  = 3'd4,
    OFF_CAPT   = 3'd5
  } off_e;

  localparam logic [PRESC_W-1:0] PSC_ONE = 1;

  logic               hit, wr, rd, tick, expire;
  logic [2:0]         offset;
  logic [31:0]        rdata_mux;
  logic               unused_addr_bits;

  logic [2:0]         ctrl_q, ctrl_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               exp_q, exp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic [31:0]        r_data_q, r_data_d;
  logic               rd_hit_q, rd_hit_d;
  logic               irq_q, irq_d;
`ifdef MMIO_TIMER_CAPTURE_EN
  logic [31:0]        capture_q, capture_d;
`endif

  assign hit              = (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
  assign offset           = bus.mem_addr[4:2];
  assign wr               = hit & bus.wr_en;
  assign rd               = hit & ~bus.wr_en;
  assign unused_addr_bits = ^bus.mem_addr[1:0];

  assign tick   = ctrl_q[0] && (psc_q == presc_q);
  assign expire = tick && (count_q == '0);

  always_comb begin
    rdata_mux = '0;
    case (offset)
      OFF_CTRL:   rdata_mux = {29'd0, ctrl_q};
      OFF_LOAD:   rdata_mux = load_q;
      OFF_COUNT:  rdata_mux = count_q;
      OFF_STATUS: rdata_mux = {31'd0, exp_q};
      OFF_PRESC:  rdata_mux = 32'(presc_q);
`ifdef MMIO_TIMER_CAPTURE_EN
      OFF_CAPT:   rdata_mux = capture_q;
`endif
      default:    rdata_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    count_d  = count_q;
    exp_d    = exp_q;
    presc_d  = presc_q;
    psc_d    = psc_q;
`ifdef MMIO_TIMER_CAPTURE_EN
    capture_d = capture_q;
`endif

    if (!ctrl_q[0] || tick) psc_d = '0;
    else                    psc_d = psc_q + PSC_ONE;

    // Tick updates first so that a same-cycle CPU write overrides them below.
    if (tick) begin
      if (count_q != '0)  count_d = count_q - 32'd1;
      else if (ctrl_q[1]) count_d = load_q;
      else                ctrl_d[0] = 1'b0;
    end

    if (wr) begin
      case (offset)
        OFF_CTRL:   ctrl_d  = bus.w_data[2:0];
        OFF_LOAD:   load_d  = bus.w_data;
        OFF_COUNT:  count_d = bus.w_data;
        OFF_STATUS: if (bus.w_data[0]) exp_d = 1'b0;
        OFF_PRESC: begin
          presc_d = bus.w_data[PRESC_W-1:0];
          psc_d   = '0;
        end
`ifdef MMIO_TIMER_CAPTURE_EN
        OFF_CAPT:   capture_d = count_q;
`endif
        default: ;
      endcase
    end

    if (expire) exp_d = 1'b1;

    r_data_d = rd ? rdata_mux : '0;
    rd_hit_d = rd;
    irq_d    = exp_d & ctrl_d[2];
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      exp_q     <= 1'b0;
      presc_q   <= '0;
      psc_q     <= '0;
      r_data_q  <= '0;
      rd_hit_q  <= 1'b0;
      irq_q     <= 1'b0;
`ifdef MMIO_TIMER_CAPTURE_EN
      capture_q <= '0;
`endif
    end else if (clk_en) begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      presc_q   <= presc_d;
      psc_q     <= psc_d;
      r_data_q  <= r_data_d;
      rd_hit_q  <= rd_hit_d;
      irq_q     <= irq_d;
`ifdef MMIO_TIMER_CAPTURE_EN
      capture_q <= capture_d;
`endif
    end
  end

  assign bus.r_data = r_data_q;
  assign bus.rd_hit = rd_hit_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboarded bench for mmio_timer: expected read data is queued at issue and
// compared one enabled cycle later when the registered response appears.
module tb_mmio_timer;

  localparam logic [31:0] BASE     = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;
  localparam logic [31:0] A_CAPT   = BASE + 32'h14;
  localparam logic [31:0] A_RSV    = BASE + 32'h18;
  localparam logic [31:0] A_MISS   = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] d;
    logic        h;
  } exp_t;

  logic clk_100M = 1'b0;
  logic rst;
  logic clk_en;
  logic irq;
  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  mmio_timer_if bus();

  mmio_timer #(.BASE_ADDR(32'hFFFF_0000), .PRESC_W(16)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .clk_en   (clk_en),
    .bus      (bus),
    .irq      (irq)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  task automatic idle_bus();
    bus.mem_addr = A_MISS;
    bus.wr_en    = 1'b0;
    bus.w_data   = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr = a;
    bus.wr_en    = 1'b1;
    bus.w_data   = d;
    cyc(1);
    idle_bus();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic eh);
    bus.mem_addr = a;
    bus.wr_en    = 1'b0;
    sb.push_back('{d: ed, h: eh});
    cyc(1);
    idle_bus();
  endtask

  task automatic do_reset();
    clk_en = 1'b1;
    idle_bus();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (irq !== 1'b0 || bus.r_data !== 32'd0 || bus.rd_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs irq=%b r_data=%h rd_hit=%b expected 0/0/0", irq, bus.r_data, bus.rd_hit);
    end
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(4 * i), 32'd0, 1'b1);
      e = sb.pop_front(); checks++;
      if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
        failures++;
        $display("FAIL reset_read[%0d] r_data=%h rd_hit=%b expected %h/%b", i, bus.r_data, bus.rd_hit, e.d, e.h);
      end
    end
    wr(A_LOAD, 32'h1234_5678);
    wr(A_RSV, 32'hFFFF_FFFF);
    rd(A_LOAD, 32'h1234_5678, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL load_readback r_data=%h rd_hit=%b expected %h/%b", bus.r_data, bus.rd_hit, e.d, e.h);
    end
    rd(A_MISS, 32'd0, 1'b0);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL miss_read r_data=%h rd_hit=%b expected %h/%b", bus.r_data, bus.rd_hit, e.d, e.h);
    end
    rd(A_RSV, 32'd0, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL reserved_read r_data=%h rd_hit=%b expected %h/%b", bus.r_data, bus.rd_hit, e.d, e.h);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] tbl [7];
    logic [31:0] adr [7];
    tbl = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0};
    adr = '{A_COUNT, A_COUNT, A_COUNT, A_COUNT, A_STATUS, A_CTRL, A_COUNT};
    do_reset();
    wr(A_PRESC, 32'd0);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 7; i++) begin
      rd(adr[i], tbl[i], 1'b1);
      e = sb.pop_front(); checks++;
      if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
        failures++;
        $display("FAIL oneshot[%0d] r_data=%h rd_hit=%b expected %h/%b", i, bus.r_data, bus.rd_hit, e.d, e.h);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_irq irq=%b expected 0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] tbl [6];
    tbl = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
    do_reset();
    wr(A_PRESC, 32'd1);
    wr(A_LOAD, 32'd2);
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 6; i++) begin
      rd(A_COUNT, tbl[i], 1'b1);
      e = sb.pop_front(); checks++;
      if (bus.r_data !== e.d || bus.rd_hit !== e.h || irq !== (i == 5)) begin
        failures++;
        $display("FAIL auto[%0d] r_data=%h rd_hit=%b irq=%b expected %h/%b irq=%b",
                 i, bus.r_data, bus.rd_hit, irq, e.d, e.h, (i == 5));
      end
    end
    rd(A_COUNT, 32'd2, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h || irq !== 1'b1) begin
      failures++;
      $display("FAIL auto_reload r_data=%h irq=%b expected %h irq=1", bus.r_data, irq, e.d);
    end
    wr(A_STATUS, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL auto_irq_clear irq=%b expected 0", irq);
    end
    rd(A_STATUS, 32'd0, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL auto_status_clear r_data=%h expected %h", bus.r_data, e.d);
    end
  endtask

  task automatic test_collisions();
    do_reset();
    wr(A_PRESC, 32'd0);
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'h10);
    rd(A_COUNT, 32'h10, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL col_count_write r_data=%h expected %h", bus.r_data, e.d);
    end

    do_reset();
    wr(A_PRESC, 32'd0);
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'h1);
    cyc(1);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'd1, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL col_status_set_wins r_data=%h expected %h", bus.r_data, e.d);
    end
    rd(A_CTRL, 32'd0, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL col_oneshot_stop r_data=%h expected %h", bus.r_data, e.d);
    end

    do_reset();
    wr(A_PRESC, 32'd0);
    wr(A_LOAD, 32'hABCD);
    wr(A_COUNT, 32'h20);
    wr(A_CTRL, 32'h1);
    rd(A_LOAD, 32'hABCD, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL gate_pre r_data=%h expected %h", bus.r_data, e.d);
    end
    clk_en       = 1'b0;
    bus.mem_addr = A_COUNT;
    bus.wr_en    = 1'b1;
    bus.w_data   = 32'h55;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++;
      if (bus.r_data !== 32'hABCD || bus.rd_hit !== 1'b1) begin
        failures++;
        $display("FAIL gate_hold[%0d] r_data=%h rd_hit=%b expected 0000abcd/1", i, bus.r_data, bus.rd_hit);
      end
    end
    idle_bus();
    clk_en = 1'b1;
    rd(A_COUNT, 32'h1F, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL gate_count r_data=%h expected %h", bus.r_data, e.d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] adr [5];
    logic [31:0] tbl [5];
    adr = '{A_COUNT, A_STATUS, A_CTRL, A_STATUS, A_STATUS};
    tbl = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    do_reset();
    wr(A_PRESC, 32'd0);
    wr(A_LOAD, 32'd5);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    rd(A_LOAD, 32'd5, 1'b1);
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h || irq !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre r_data=%h irq=%b expected %h irq=1", bus.r_data, irq, e.d);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0 || bus.r_data !== 32'd0 || bus.rd_hit !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate irq=%b r_data=%h rd_hit=%b expected 0/0/0", irq, bus.r_data, bus.rd_hit);
    end
    #2 rst = 1'b0;
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) wr(A_CTRL, 32'h1);
      rd(adr[i], tbl[i], 1'b1);
      e = sb.pop_front(); checks++;
      if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
        failures++;
        $display("FAIL arst_post[%0d] r_data=%h expected %h", i, bus.r_data, e.d);
      end
    end
  endtask

  task automatic test_capture();
    do_reset();
    wr(A_PRESC, 32'd0);
    wr(A_COUNT, 32'd100);
    wr(A_CTRL, 32'h1);
    cyc(1);
    wr(A_CAPT, 32'hDEAD_BEEF);
`ifdef MMIO_TIMER_CAPTURE_EN
    rd(A_CAPT, 32'd99, 1'b1);
`else
    rd(A_CAPT, 32'd0, 1'b1);
`endif
    e = sb.pop_front(); checks++;
    if (bus.r_data !== e.d || bus.rd_hit !== e.h) begin
      failures++;
      $display("FAIL capture r_data=%h expected %h", bus.r_data, e.d);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    clk_en = 1'b1;
    idle_bus();
    cyc(1);
    test_reset();
    test_oneshot();
    test_autoreload();
    test_collisions();
    test_async_reset();
    test_capture();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
